nrisc_ula_seq: RTL and testbench

NRISC_ULA_SEQ -- requirements
Module: nrisc_ula_seq

---
 rtl/nrisc_ula_seq.sv | 212 +++++++++++++++++++++
 tb/tb_nrisc_ula_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_ula_seq.sv
`default_nettype none
// ============================================================================
// Module      : nrisc_ula_seq
// Description : Sequential ALU with a valid/ready handshake on both sides.
//               Most opcodes finish in one cycle. MUL uses one shift-add
//               step per cycle, and SHRN shifts one bit per cycle.
//               Results stay in registers until the consumer takes them.
// Revision    : 1.0 - initial release
// ============================================================================
module nrisc_ula_seq #(
    parameter int TAM    = 16,
    parameter int MUL_EN = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    input  logic           incdec,
    input  logic [3:0]     ULA_ctrl,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags,
    output logic           ULA_err
);

    localparam int c_NW = $clog2(TAM);
    localparam int c_CW = c_NW + 1;
    localparam logic [c_CW-1:0] c_CNT_TAM = c_CW'(TAM);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SUB  = 4'b0001;
    localparam logic [3:0] c_OP_AND  = 4'b0010;
    localparam logic [3:0] c_OP_OR   = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SHR  = 4'b0101;
    localparam logic [3:0] c_OP_SHL  = 4'b0110;
    localparam logic [3:0] c_OP_NOT  = 4'b0111;
    localparam logic [3:0] c_OP_MUL  = 4'b1000;
    localparam logic [3:0] c_OP_SHRN = 4'b1001;
    localparam logic [3:0] c_OP_RTR  = 4'b1101;
    localparam logic [3:0] c_OP_RTL  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [TAM-1:0]  r_out;
    logic [2:0]      r_flags;
    logic            r_err;
    logic [TAM-1:0]  r_acc;      // MUL partial product, or the SHRN working value
    logic [TAM-1:0]  r_mcand;    // multiplicand, shifted left each step
    logic [TAM-1:0]  r_mplier;   // multiplier, shifted right each step
    logic [c_CW-1:0] r_cnt;
    logic            r_op_mul;

    logic            w_accept;
    logic            w_is_mul;
    logic            w_is_multi;
    logic [c_NW-1:0] w_shrn_n;
    logic [TAM-1:0]  w_b_eff;
    logic [TAM:0]    w_sum;
    logic [TAM-1:0]  w_diff;
    logic [TAM-1:0]  w_res;
    logic            w_neg;
    logic            w_carry;
    logic            w_err;
    logic [2:0]      w_flags;
    logic [TAM-1:0]  w_step_res;
    logic            w_last_step;

    assign in_ready   = (r_state == S_IDLE) | ((r_state == S_DONE) & out_ready);
    assign out_valid  = (r_state == S_DONE);
    assign ULA_OUT    = r_out;
    assign ULA_flags  = r_flags;
    assign ULA_err    = r_err;

    assign w_accept    = in_valid & in_ready;
    assign w_is_mul    = (ULA_ctrl == c_OP_MUL) && (MUL_EN != 0);
    assign w_shrn_n    = ULA_B[c_NW-1:0];
    // A shift count of zero needs no iterations, so it completes in one cycle
    assign w_is_multi  = w_is_mul || ((ULA_ctrl == c_OP_SHRN) && (w_shrn_n != '0));
    assign w_last_step = (r_cnt == c_CNT_ONE);

    // Result of one iteration: an add-if-set step for MUL, a one-bit arithmetic shift for SHRN
    assign w_step_res = r_op_mul ? (r_acc + (r_mplier[0] ? r_mcand : '0))
                                 : {r_acc[TAM-1], r_acc[TAM-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: an accept in DONE behaves exactly like an accept in IDLE
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = w_is_multi ? S_BUSY : S_DONE;
            end
            S_BUSY: begin
                if (w_last_step) w_state_next = S_DONE;
            end
            S_DONE: begin
                if (w_accept)       w_state_next = w_is_multi ? S_BUSY : S_DONE;
                else if (out_ready) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Single-cycle results and flags, computed from the live request inputs
    always_comb begin
        w_b_eff = incdec ? {{(TAM-1){1'b0}}, 1'b1} : ULA_B;
        w_sum   = {1'b0, ULA_A} + {1'b0, w_b_eff};
        w_diff  = ULA_A - w_b_eff;
        w_res   = '0;
        w_neg   = 1'b0;
        w_carry = 1'b0;
        w_err   = 1'b0;
        case (ULA_CTRL_SEL(ULA_ctrl))
            c_OP_ADD: begin
                w_res   = w_sum[TAM-1:0];
                w_carry = w_sum[TAM];
                // A signed overflow flips the sign bit, so XOR it back in
                w_neg   = w_sum[TAM-1] ^ ((ULA_A[TAM-1] == w_b_eff[TAM-1]) &&
                                          (w_sum[TAM-1] != ULA_A[TAM-1]));
            end
            c_OP_SUB: begin
                w_res   = w_diff;
                w_carry = (ULA_A < w_b_eff);
                w_neg   = w_diff[TAM-1] ^ ((ULA_A[TAM-1] != w_b_eff[TAM-1]) &&
                                           (w_diff[TAM-1] != ULA_A[TAM-1]));
            end
            c_OP_AND: w_res = ULA_A & ULA_B;
            c_OP_OR:  w_res = ULA_A | ULA_B;
            c_OP_XOR: w_res = ULA_A ^ ULA_B;
            c_OP_SHR: begin
                w_res   = {ULA_A[TAM-1], ULA_A[TAM-1:1]};
                w_carry = ULA_A[0];
            end
            c_OP_RTR: w_res = {ULA_A[0], ULA_A[TAM-1:1]};
            c_OP_SHL: begin
                w_res   = {ULA_A[TAM-2:0], 1'b0};
                w_carry = ULA_A[TAM-1];
            end
            c_OP_RTL: w_res = {ULA_A[TAM-2:0], ULA_A[TAM-1]};
            c_OP_NOT: w_res = ~ULA_A;
            // This path is only used when MUL is disabled; otherwise MUL is iterative
            c_OP_MUL: w_err = (MUL_EN == 0);
            // This path is only used for SHRN by zero; nonzero counts are iterative
            c_OP_SHRN: w_res = ULA_A;
            default:  w_err = 1'b1;
        endcase
        w_flags = w_err ? 3'b010 : {w_neg, (w_res == '0), w_carry};
    end

    function automatic logic [3:0] ULA_CTRL_SEL(input logic [3:0] op);
        return op;
    endfunction

    // Datapath: capture on accept, iterate while BUSY, and publish the result on the last step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out    <= '0;
            r_flags  <= 3'b000;
            r_err    <= 1'b0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_op_mul <= 1'b0;
        end else if (w_accept) begin
            if (w_is_multi) begin
                r_op_mul <= w_is_mul;
                r_acc    <= w_is_mul ? '0 : ULA_A;
                r_mcand  <= ULA_A;
                r_mplier <= ULA_B;
                r_cnt    <= w_is_mul ? c_CNT_TAM : {1'b0, w_shrn_n};
            end else begin
                r_out   <= w_res;
                r_flags <= w_flags;
                r_err   <= w_err;
            end
        end else if (r_state == S_BUSY) begin
            r_cnt    <= r_cnt - c_CNT_ONE;
            r_acc    <= w_step_res;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last_step) begin
                r_out   <= w_step_res;
                // For SHRN, the bit leaving on the final step is the carry
                r_flags <= {1'b0, (w_step_res == '0), (r_op_mul ? 1'b0 : r_acc[0])};
                r_err   <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nrisc_ula_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_nrisc_ula_seq
// Description : Self-checking bench for nrisc_ula_seq (TAM=16, MUL_EN=1).
//               It combines directed vectors, handshake and reset sequences,
//               and random operations that are checked against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nrisc_ula_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] ULA_A = '0;
    logic [15:0] ULA_B = '0;
    logic        incdec = 1'b0;
    logic [3:0]  ULA_ctrl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] ULA_OUT;
    logic [2:0]  ULA_flags;
    logic        ULA_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nrisc_ula_seq #(.TAM(16), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ULA_A     (ULA_A),
        .ULA_B     (ULA_B),
        .incdec    (incdec),
        .ULA_ctrl  (ULA_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ULA_OUT   (ULA_OUT),
        .ULA_flags (ULA_flags),
        .ULA_err   (ULA_err)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        bit          inc;
        logic [15:0] out;
        logic [2:0]  flags;
        bit          err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [15:0] out;
        logic [2:0]  flags;
        bit          err;
        int          lat;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model built from arithmetic on wide integers
    function automatic exp_t model(input logic [3:0] op, input logic [15:0] a,
                                   input logic [15:0] b, input bit inc);
        exp_t    e;
        longint  ua, ub, sa, sb, r;
        int      n;
        bit      neg, carry;
        e.out = '0; e.flags = '0; e.err = 1'b0; e.lat = 1;
        neg = 1'b0; carry = 1'b0;
        ua = longint'(a);
        ub = inc ? 64'sd1 : longint'(b);
        sa = (ua >= 32768) ? ua - 65536 : ua;
        sb = (ub >= 32768) ? ub - 65536 : ub;
        case (op)
            4'd0:  begin r = ua + ub; e.out = 16'(r); carry = (r > 65535); neg = (sa + sb) < 0; end
            4'd1:  begin r = ua - ub; e.out = 16'(r); carry = (ua < ub);   neg = (sa - sb) < 0; end
            4'd2:  e.out = a & b;
            4'd3:  e.out = a | b;
            4'd4:  e.out = a ^ b;
            4'd5:  begin e.out = 16'(sa >>> 1); carry = a[0]; end
            4'd13: e.out = 16'((ua >> 1) | (ua << 15));
            4'd6:  begin e.out = 16'(ua << 1); carry = a[15]; end
            4'd14: e.out = 16'((ua << 1) | (ua >> 15));
            4'd7:  e.out = ~a;
            4'd8:  begin e.out = 16'(ua * longint'(b)); e.lat = 17; end
            4'd9:  begin
                n = int'(b[3:0]);
                e.out = 16'(sa >>> n);
                carry = (n == 0) ? 1'b0 : 1'(ua >> (n - 1));
                e.lat = n + 1;
            end
            default: e.err = 1'b1;
        endcase
        if (e.err) begin
            e.out = '0;
            e.flags = 3'b010;
        end else begin
            e.flags = {neg, (e.out == 16'h0000), carry};
        end
        return e;
    endfunction

    // Issue one request, measure latency, check result, optionally stall, then consume
    task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                          input bit inc, input logic [15:0] eo, input logic [2:0] ef,
                          input bit ee, input int elat, input int hold, input string tag);
        int lat;
        in_valid = 1'b1; ULA_ctrl = op; ULA_A = a; ULA_B = b; incdec = inc; out_ready = 1'b0;
        chk({tag, " in_ready_idle"}, 32'(in_ready), 1);
        @(posedge clk); #1;
        // Inputs may change after accept without affecting the operation in flight
        in_valid = 1'($urandom); ULA_A = 16'($urandom); ULA_B = 16'($urandom);
        ULA_ctrl = 4'($urandom); incdec = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 64) begin
            chk({tag, " in_ready_busy"}, 32'(in_ready), 0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, " latency"}, 32'(lat), 32'(elat));
        chk({tag, " out_valid"}, 32'(out_valid), 1);
        chk({tag, " ULA_OUT"}, 32'(ULA_OUT), 32'(eo));
        chk({tag, " ULA_flags"}, 32'(ULA_flags), 32'(ef));
        chk({tag, " ULA_err"}, 32'(ULA_err), 32'(ee));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk({tag, " hold_out"}, 32'(ULA_OUT), 32'(eo));
            chk({tag, " hold_flags"}, 32'(ULA_flags), 32'(ef));
            chk({tag, " hold_valid"}, 32'(out_valid), 1);
            chk({tag, " hold_in_ready"}, 32'(in_ready), 0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " consumed"}, 32'(out_valid), 0);
    endtask

    vec_t vecs[19];

    initial begin
        exp_t e;
        logic [3:0]  rop;
        logic [15:0] ra, rb;
        bit          rinc;
        bit          seen;

        //          op     a         b        inc   out       flags  err lat
        vecs[0]  = '{4'd0,  16'h7FFF, 16'h0001, 1'b0, 16'h8000, 3'b000, 1'b0, 1};
        vecs[1]  = '{4'd1,  16'h0003, 16'h0005, 1'b0, 16'hFFFE, 3'b101, 1'b0, 1};
        vecs[2]  = '{4'd1,  16'h0003, 16'h1234, 1'b1, 16'h0002, 3'b000, 1'b0, 1};
        vecs[3]  = '{4'd8,  16'h00FF, 16'h0101, 1'b0, 16'hFFFF, 3'b000, 1'b0, 17};
        vecs[4]  = '{4'd9,  16'h8010, 16'h0005, 1'b0, 16'hFC00, 3'b001, 1'b0, 6};
        vecs[5]  = '{4'd9,  16'h8010, 16'h0000, 1'b0, 16'h8010, 3'b000, 1'b0, 1};
        vecs[6]  = '{4'd0,  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 3'b011, 1'b0, 1};
        vecs[7]  = '{4'd10, 16'h1234, 16'h5678, 1'b0, 16'h0000, 3'b010, 1'b1, 1};
        vecs[8]  = '{4'd6,  16'h8001, 16'h0000, 1'b0, 16'h0002, 3'b001, 1'b0, 1};
        vecs[9]  = '{4'd14, 16'h8001, 16'h0000, 1'b0, 16'h0003, 3'b000, 1'b0, 1};
        vecs[10] = '{4'd5,  16'h8001, 16'h0000, 1'b0, 16'hC000, 3'b001, 1'b0, 1};
        vecs[11] = '{4'd1,  16'h8000, 16'h0001, 1'b0, 16'h7FFF, 3'b100, 1'b0, 1};
        vecs[12] = '{4'd0,  16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 3'b000, 1'b0, 1};
        vecs[13] = '{4'd2,  16'h0F0F, 16'h00FF, 1'b1, 16'h000F, 3'b000, 1'b0, 1};
        vecs[14] = '{4'd4,  16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 3'b010, 1'b0, 1};
        vecs[15] = '{4'd7,  16'hFFFF, 16'h0000, 1'b0, 16'h0000, 3'b010, 1'b0, 1};
        vecs[16] = '{4'd13, 16'h0001, 16'h0000, 1'b0, 16'h8000, 3'b000, 1'b0, 1};
        vecs[17] = '{4'd3,  16'h1200, 16'h0034, 1'b0, 16'h1234, 3'b000, 1'b0, 1};
        vecs[18] = '{4'd9,  16'h7FFF, 16'h00FF, 1'b0, 16'h0000, 3'b011, 1'b0, 16};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", 32'(out_valid), 0);
        chk("reset ULA_OUT", 32'(ULA_OUT), 0);
        chk("reset ULA_flags", 32'(ULA_flags), 0);
        chk("reset ULA_err", 32'(ULA_err), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post-reset in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;

        // Directed vectors
        for (int i = 0; i < 19; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inc, vecs[i].out,
                   vecs[i].flags, vecs[i].err, vecs[i].lat, i % 3, $sformatf("vec%0d", i));
        end

        // Stall in DONE, then consume and accept on the same edge
        in_valid = 1'b1; ULA_ctrl = 4'd0; ULA_A = 16'h0001; ULA_B = 16'h0002; incdec = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b first valid", 32'(out_valid), 1);
        chk("b2b first out", 32'(ULA_OUT), 32'h0003);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("b2b stall out", 32'(ULA_OUT), 32'h0003);
            chk("b2b stall in_ready", 32'(in_ready), 0);
            chk("b2b stall valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1; in_valid = 1'b1; ULA_ctrl = 4'hF; ULA_A = 16'hBEEF;
        #1;
        chk("b2b in_ready with out_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b second valid", 32'(out_valid), 1);
        chk("b2b illegal err", 32'(ULA_err), 1);
        chk("b2b illegal out", 32'(ULA_OUT), 0);
        chk("b2b illegal flags", 32'(ULA_flags), 32'b010);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("b2b consumed", 32'(out_valid), 0);

        // Reset in the middle of a MUL
        run_op(4'd0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 3'b000, 1'b0, 1, 0, "pre-rst");
        in_valid = 1'b1; ULA_ctrl = 4'd8; ULA_A = 16'h0003; ULA_B = 16'h0005;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        chk("mid-mul busy", 32'(out_valid), 0);
        rst = 1'b0;
        #1;
        chk("rst ULA_OUT", 32'(ULA_OUT), 0);
        chk("rst ULA_flags", 32'(ULA_flags), 0);
        chk("rst ULA_err", 32'(ULA_err), 0);
        chk("rst out_valid", 32'(out_valid), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("no result after abort", 32'(seen), 0);
        run_op(4'd8, 16'h0003, 16'h0005, 1'b0, 16'h000F, 3'b000, 1'b0, 17, 1, "post-rst mul");

        // Random operations against the model
        for (int i = 0; i < 150; i++) begin
            rop  = 4'($urandom);
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rinc = 1'($urandom);
            e = model(rop, ra, rb, rinc);
            run_op(rop, ra, rb, rinc, e.out, e.flags, e.err, e.lat,
                   $urandom_range(0, 2), $sformatf("rnd%0d op%0d", i, rop));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
